fc_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares the single first-cell write path (the cell stream feeding the first-cell FIFO writer) among NREQ cell sources in the msg_ta datapath. The grant locks on an SOP cell and holds until that packet's EOP cell is accepted, so cells of different packets never interleave. The output is one registered valid/ready stage tagged with the source index, driven toward the first-cell writer and throttled by its almost-full indication.

---
 rtl/fc_pkg.sv | 15 +
 rtl/fc_rr_pick.sv | 27 ++
 rtl/fc_arb.sv | 165 ++++++++++++++++
 tb/tb_fc_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FSM state type and cell-flag constants for fc_arb
package fc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } fc_state_e;

  localparam int FC_SOP_BIT = 1;
  localparam int FC_EOP_BIT = 0;
  localparam int FC_ERR_W   = 16;

  localparam logic [FC_ERR_W-1:0] FC_ERR_MAX = {FC_ERR_W{1'b1}};

endpackage

// File: rtl/fc_rr_pick.sv
// rtl/fc_rr_pick.sv - combinational round-robin pick: first set request at or after ptr
module fc_rr_pick #(
  parameter int NREQ  = 4,
  parameter int SID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SID_W-1:0] ptr,
  output logic             found,
  output logic [SID_W-1:0] idx
);

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NREQ;
      if (req[cand]) begin
        found = 1'b1;
        idx   = SID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fc_arb.sv
// rtl/fc_arb.sv - packet-atomic round-robin arbiter onto the first-cell write path
// Orphan-cell dropping and err_cnt are enabled by defining FC_ARB_ERR_EN.
module fc_arb
  import fc_pkg::*;
#(
  parameter int DWID    = 128,
  parameter int NREQ    = 4,
  parameter int SOP_BIT = FC_SOP_BIT,
  parameter int EOP_BIT = FC_EOP_BIT,
  parameter int SID_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_cell_vld,
  output logic [NREQ-1:0]      req_cell_rdy,
  input  logic [NREQ*DWID-1:0] req_cell_dat,
  output logic                 out_cell_vld,
  input  logic                 out_cell_rdy,
  output logic [DWID-1:0]      out_cell_dat,
  output logic [SID_W-1:0]     out_src_id,
  output logic [FC_ERR_W-1:0]  err_cnt
);

  fc_state_e        state, state_nxt;
  logic [SID_W-1:0] rr_ptr, rr_nxt;
  logic [SID_W-1:0] gnt_id, gnt_nxt;
  logic [NREQ-1:0]  sop_vec, eop_vec, elig;
  logic             can_load;
  logic             load;
  logic [SID_W-1:0] load_id;
  logic [DWID-1:0]  load_dat;
  logic             win_found;
  logic [SID_W-1:0] win_id;

  function automatic logic [SID_W-1:0] ptr_inc(input logic [SID_W-1:0] p);
    return (p == SID_W'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sop_vec = '0;
    eop_vec = '0;
    for (int k = 0; k < NREQ; k++) begin
      sop_vec[k] = req_cell_dat[k*DWID + SOP_BIT];
      eop_vec[k] = req_cell_dat[k*DWID + EOP_BIT];
    end
  end

  assign elig     = req_cell_vld & sop_vec;
  assign can_load = !out_cell_vld || out_cell_rdy;
  assign load_dat = req_cell_dat[int'(load_id)*DWID +: DWID];

  fc_rr_pick #(
    .NREQ  (NREQ),
    .SID_W (SID_W)
  ) u_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .found (win_found),
    .idx   (win_id)
  );

`ifdef FC_ARB_ERR_EN
  logic [NREQ-1:0]  orph_vec;
  logic             orph_found;
  logic [SID_W-1:0] orph_id;
  logic             drop;

  assign orph_vec = req_cell_vld & ~sop_vec;

  always_comb begin
    orph_found = 1'b0;
    orph_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (orph_vec[k]) begin
        orph_found = 1'b1;
        orph_id    = SID_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    gnt_nxt      = gnt_id;
    req_cell_rdy = '0;
    load         = 1'b0;
    load_id      = gnt_id;
`ifdef FC_ARB_ERR_EN
    drop         = 1'b0;
`endif
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (win_found) begin
            req_cell_rdy[win_id] = can_load;
            if (can_load) begin
              load    = 1'b1;
              load_id = win_id;
              if (eop_vec[win_id]) begin
                rr_nxt = ptr_inc(win_id);
              end else begin
                state_nxt = ST_LOCK;
                gnt_nxt   = win_id;
              end
            end
          end
`ifdef FC_ARB_ERR_EN
          // Orphans are only flushed when no packet start competes this cycle.
          else if (orph_found) begin
            req_cell_rdy[orph_id] = can_load;
            drop                  = can_load;
          end
`endif
        end
        ST_LOCK: begin
          req_cell_rdy[gnt_id] = can_load;
          if (can_load && req_cell_vld[gnt_id]) begin
            load = 1'b1;
            if (eop_vec[gnt_id]) begin
              state_nxt = ST_IDLE;
              rr_nxt    = ptr_inc(gnt_id);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      gnt_id       <= '0;
      out_cell_vld <= 1'b0;
      out_cell_dat <= '0;
      out_src_id   <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      gnt_id <= gnt_nxt;
      if (load) begin
        out_cell_vld <= 1'b1;
        out_cell_dat <= load_dat;
        out_src_id   <= load_id;
      end else if (out_cell_rdy) begin
        out_cell_vld <= 1'b0;
      end
    end
  end

`ifdef FC_ARB_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (drop && err_cnt != FC_ERR_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fc_arb.sv
// tb/tb_fc_arb.sv - randomized self-checking bench for fc_arb against a packet-level model
module tb_fc_arb;

  localparam int NREQ  = 4;
  localparam int DWID  = 128;
  localparam int SID_W = 2;
  localparam int SOPB  = 1;
  localparam int EOPB  = 0;
  localparam int QD    = 1024;
`ifdef FC_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_cell_vld = '0;
  logic [NREQ-1:0]      req_cell_rdy;
  logic [NREQ*DWID-1:0] req_cell_dat = '0;
  logic                 out_cell_vld;
  logic                 out_cell_rdy = 1'b1;
  logic [DWID-1:0]      out_cell_dat;
  logic [SID_W-1:0]     out_src_id;
  logic [15:0]          err_cnt;

  fc_arb #(.DWID(DWID), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_cell_vld (req_cell_vld),
    .req_cell_rdy (req_cell_rdy),
    .req_cell_dat (req_cell_dat),
    .out_cell_vld (out_cell_vld),
    .out_cell_rdy (out_cell_rdy),
    .out_cell_dat (out_cell_dat),
    .out_src_id   (out_src_id),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Per-requester cell queues (circular) holding the packets each source still has to send.
  logic [DWID-1:0] mem [NREQ][QD];
  int hd [NREQ];
  int tl [NREQ];

  // Packet-level model: owner of the path (-1 = free), next preferred index, output stage.
  int              m_own;
  int              m_rr;
  bit              m_vld;
  logic [DWID-1:0] m_dat;
  int              m_id;
  int              m_err;

  task automatic chk(input string tag, input logic [DWID-1:0] got, input logic [DWID-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DWID-1:0] rnd_cell();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_cell(input int k, input logic [DWID-1:0] c);
    mem[k][tl[k] % QD] = c;
    tl[k]++;
  endtask

  task automatic push_pkt(input int k, input int len);
    logic [DWID-1:0] c;
    for (int i = 0; i < len; i++) begin
      c = rnd_cell();
      c[SOPB] = (i == 0);
      c[EOPB] = (i == len - 1);
      push_cell(k, c);
    end
  endtask

  task automatic push_orphan(input int k);
    logic [DWID-1:0] c;
    c = rnd_cell();
    c[SOPB] = 1'b0;
    push_cell(k, c);
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NREQ; k++) s += tl[k] - hd[k];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    req_cell_vld = '0;
    out_cell_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", DWID'(out_cell_vld), '0);
    chk("rst_out_dat", out_cell_dat, '0);
    chk("rst_out_src", DWID'(out_src_id), '0);
    chk("rst_err_cnt", DWID'(err_cnt), '0);
    chk("rst_req_rdy", DWID'(req_cell_rdy), '0);
    rst = 1'b0;
    m_own = -1; m_rr = 0; m_vld = 1'b0; m_dat = '0; m_id = 0; m_err = 0;
    for (int k = 0; k < NREQ; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
  endtask

  // One clock: check registered outputs, drive new inputs, check ready, then advance the model.
  task automatic step(input int vld_pct, input int ordy_pct);
    logic [NREQ-1:0] er;
    logic [DWID-1:0] c;
    int              win, orph, acc;
    bit              can_load, fwd;
    @(negedge clk);
    chk("out_vld", DWID'(out_cell_vld), DWID'(m_vld));
    chk("out_dat", out_cell_dat, m_dat);
    chk("out_src", DWID'(out_src_id), DWID'(m_id));
    chk("err_cnt", DWID'(err_cnt), DWID'(m_err));
    for (int k = 0; k < NREQ; k++) begin
      if (tl[k] != hd[k] && $urandom_range(99) < vld_pct) begin
        req_cell_vld[k]                = 1'b1;
        req_cell_dat[k*DWID +: DWID]   = mem[k][hd[k] % QD];
      end else begin
        req_cell_vld[k]                = 1'b0;
        req_cell_dat[k*DWID +: DWID]   = rnd_cell();
      end
    end
    out_cell_rdy = ($urandom_range(99) < ordy_pct);
    #2;
    can_load = !m_vld || out_cell_rdy;
    er = '0;
    if (m_own >= 0) begin
      er[m_own] = can_load;
    end else begin
      win  = -1;
      orph = -1;
      for (int i = 0; i < NREQ && win < 0; i++)
        if (req_cell_vld[(m_rr + i) % NREQ] && req_cell_dat[((m_rr + i) % NREQ)*DWID + SOPB])
          win = (m_rr + i) % NREQ;
      for (int k = NREQ - 1; k >= 0; k--)
        if (req_cell_vld[k] && !req_cell_dat[k*DWID + SOPB]) orph = k;
      if (win >= 0) er[win] = can_load;
      else if (ERR_EN && orph >= 0) er[orph] = can_load;
    end
    chk("req_rdy", DWID'(req_cell_rdy), DWID'(er));
    @(posedge clk);
    acc = -1;
    for (int k = 0; k < NREQ; k++) if (er[k] && req_cell_vld[k]) acc = k;
    fwd = 1'b0;
    if (acc >= 0) begin
      c = mem[acc][hd[acc] % QD];
      hd[acc]++;
      if (m_own >= 0) begin
        fwd = 1'b1;
        if (c[EOPB]) begin
          m_own = -1;
          m_rr  = (acc + 1) % NREQ;
        end
      end else if (c[SOPB]) begin
        fwd = 1'b1;
        if (c[EOPB]) m_rr = (acc + 1) % NREQ;
        else m_own = acc;
      end else begin
        m_err = (m_err == 65535) ? 65535 : m_err + 1;
      end
    end
    if (fwd) begin
      m_vld = 1'b1;
      m_dat = c;
      m_id  = acc;
    end else if (out_cell_rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && pending() > 0; i++) step(100, 100);
    step(100, 100);
    step(100, 100);
    chk("drain_left", DWID'(pending()), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    step(100, 100);

    // three-cell packet from req0
    push_pkt(0, 3);
    drain();

    // req1 and req2 contend from the same cycle
    do_reset();
    push_pkt(1, 2);
    push_pkt(2, 2);
    drain();

    // downstream stalls mid-packet for five cycles
    do_reset();
    push_pkt(0, 6);
    push_pkt(1, 2);
    for (int cyc = 0; cyc < 12; cyc++) step(100, (cyc >= 2 && cyc < 7) ? 0 : 100);
    drain();

    // single-cell packets from every requester
    do_reset();
    for (int k = 0; k < NREQ; k++) push_pkt(k, 1);
    drain();

    // reset lands in the middle of a req3 packet
    do_reset();
    push_pkt(3, 4);
    step(100, 100);
    step(100, 100);
    do_reset();
    push_pkt(0, 2);
    drain();

    // orphan cell from req2 while idle
    do_reset();
    push_orphan(2);
    for (int i = 0; i < 5; i++) step(100, 100);
    do_reset();

    // randomized traffic with random source valid and downstream ready
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (tl[k] - hd[k] < 6 && $urandom_range(7) == 0) begin
          if (ERR_EN && $urandom_range(9) == 0) push_orphan(k);
          push_pkt(k, $urandom_range(1, 5));
        end
      end
      step(75, 70);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
